// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Forwarding, load-use stall, mul/div sequencing and branch flush
//            control for the 5-stage pipeline. Optional PIPE_HAZ_PERF_EN adds
//            stall/flush performance counters.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MD_CYCLES = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic       dmd,
    input  logic       dtaken,
    input  logic [4:0] ern,
    input  logic [4:0] mrn,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic       mwreg,
    input  logic       mm2reg,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       wpcir,
    output logic       dbubble,
    output logic       dflush,
    output logic       md_start,
    output logic       md_busy
`ifdef PIPE_HAZ_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [3:0] c_md_load = 4'(MD_CYCLES - 2);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_lu;
    logic       w_dmd;

    function automatic logic [1:0] f_fwd(
        input logic [4:0] src,
        input logic [4:0] e_rn,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] m_rn,
        input logic       m_wreg,
        input logic       m_m2reg
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (e_wreg && (e_rn != 5'd0) && (e_rn == src) && !e_m2reg)
            sel = 2'd1;
        else if (m_wreg && (m_rn != 5'd0) && (m_rn == src))
            sel = m_m2reg ? 2'd3 : 2'd2;
        return sel;
    endfunction

    // Everything is forced quiet while reset is held, independent of inputs.
    assign fwda = resetn ? f_fwd(rs, ern, ewreg, em2reg, mrn, mwreg, mm2reg) : 2'd0;
    assign fwdb = resetn ? f_fwd(rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg) : 2'd0;

    assign w_lu = resetn & ewreg & em2reg & (ern != 5'd0) &
                  ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
    assign w_dmd = resetn & dmd;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        wpcir       = 1'b1;
        dbubble     = 1'b0;
        md_start    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_lu) begin
                    wpcir   = 1'b0;
                    dbubble = 1'b1;
                end else if (w_dmd) begin
                    md_start    = 1'b1;
                    wpcir       = 1'b0;
                    dbubble     = 1'b1;
                    w_cnt_nxt   = c_md_load;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                wpcir   = 1'b0;
                dbubble = 1'b1;
                if (r_cnt == 4'd0)
                    w_state_nxt = S_ISSUE;
                else
                    w_cnt_nxt = r_cnt - 4'd1;
            end
            S_ISSUE: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign dflush  = resetn & dtaken & wpcir;
    assign md_busy = (r_state != S_RUN);

`ifdef PIPE_HAZ_PERF_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!wpcir)
                stall_cnt <= stall_cnt + 32'd1;
            if (dflush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed and randomized bench for pipe_hazard_ctrl against a
//            cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_md = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic [4:0] rs, rt, ern, mrn;
    logic       use_rs, use_rt, dmd, dtaken, ewreg, em2reg, mwreg, mm2reg;
    logic [1:0] fwda, fwdb;
    logic       wpcir, dbubble, dflush, md_start, md_busy;
`ifdef PIPE_HAZ_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(.MD_CYCLES(c_md)) dut (
        .clock(clock), .resetn(resetn), .rs(rs), .rt(rt),
        .use_rs(use_rs), .use_rt(use_rt), .dmd(dmd), .dtaken(dtaken),
        .ern(ern), .mrn(mrn), .ewreg(ewreg), .em2reg(em2reg),
        .mwreg(mwreg), .mm2reg(mm2reg), .fwda(fwda), .fwdb(fwdb),
        .wpcir(wpcir), .dbubble(dbubble), .dflush(dflush),
        .md_start(md_start), .md_busy(md_busy)
`ifdef PIPE_HAZ_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: remaining WAIT cycles plus a pending ISSUE flag.
    int          m_waits;
    bit          m_issue;
    logic [31:0] m_stall, m_flush;
    logic        e_wpcir, e_dbubble, e_dflush, e_start, e_busy;
    logic        o_wpcir, o_start;

    function automatic logic [1:0] ref_fwd(input logic [4:0] r);
        if (ewreg && ern != 0 && ern == r && !em2reg) return 2'd1;
        if (mwreg && mrn != 0 && mrn == r) return mm2reg ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic bit ref_lu();
        return ewreg && em2reg && ern != 0 &&
               ((use_rs && ern == rs) || (use_rt && ern == rt));
    endfunction

    task automatic model_reset();
        m_waits = 0;
        m_issue = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic compute_exp();
        e_busy = (m_waits > 0) || m_issue;
        e_start = 1'b0;
        if (m_waits > 0)      begin e_wpcir = 1'b0; e_dbubble = 1'b1; end
        else if (m_issue)     begin e_wpcir = 1'b1; e_dbubble = 1'b0; end
        else if (ref_lu())    begin e_wpcir = 1'b0; e_dbubble = 1'b1; end
        else if (dmd)         begin e_wpcir = 1'b0; e_dbubble = 1'b1; e_start = 1'b1; end
        else                  begin e_wpcir = 1'b1; e_dbubble = 1'b0; end
        e_dflush = dtaken & e_wpcir;
    endtask

    task automatic step();
        @(negedge clock);
        compute_exp();
        check_eq("fwda", 32'(fwda), 32'(ref_fwd(rs)));
        check_eq("fwdb", 32'(fwdb), 32'(ref_fwd(rt)));
        check_eq("wpcir", 32'(wpcir), 32'(e_wpcir));
        check_eq("dbubble", 32'(dbubble), 32'(e_dbubble));
        check_eq("dflush", 32'(dflush), 32'(e_dflush));
        check_eq("md_start", 32'(md_start), 32'(e_start));
        check_eq("md_busy", 32'(md_busy), 32'(e_busy));
`ifdef PIPE_HAZ_PERF_EN
        check_eq("stall_cnt", stall_cnt, m_stall);
        check_eq("flush_cnt", flush_cnt, m_flush);
`endif
        o_wpcir = wpcir;
        o_start = md_start;
        @(posedge clock);
        if (!e_wpcir) m_stall = m_stall + 1;
        if (e_dflush) m_flush = m_flush + 1;
        if (m_waits > 0) begin
            m_waits--;
            if (m_waits == 0) m_issue = 1;
        end else if (m_issue) begin
            m_issue = 0;
        end else if (!ref_lu() && dmd) begin
            m_waits = c_md - 1;
        end
        #1;
    endtask

    task automatic idle();
        rs = 0; rt = 0; ern = 0; mrn = 0;
        use_rs = 0; use_rt = 0; dmd = 0; dtaken = 0;
        ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_fwda"}, 32'(fwda), 32'd0);
        check_eq({tag, "_wpcir"}, 32'(wpcir), 32'd1);
        check_eq({tag, "_dbubble"}, 32'(dbubble), 32'd0);
        check_eq({tag, "_dflush"}, 32'(dflush), 32'd0);
        check_eq({tag, "_md_start"}, 32'(md_start), 32'd0);
        check_eq({tag, "_md_busy"}, 32'(md_busy), 32'd0);
`ifdef PIPE_HAZ_PERF_EN
        check_eq({tag, "_stall_cnt"}, stall_cnt, 32'd0);
        check_eq({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
    endtask

    // Holds dmd for a whole sequence and returns start pulses and stall cycles.
    task automatic md_sequence(output int starts, output int stalls);
        starts = 0;
        stalls = 0;
        dmd = 1;
        for (int i = 0; i < c_md + 1; i++) begin
            dtaken = (i == 2) || (i == c_md);
            step();
            starts += int'(o_start);
            stalls += int'(!o_wpcir);
        end
        idle();
    endtask

    int starts, stalls;

    initial begin
        idle();
        model_reset();
        resetn = 0;
        rs = 5; ern = 5; ewreg = 1; dtaken = 1; dmd = 1;
        #12;
        check_reset_outputs("rst");
        idle();
        @(negedge clock);
        resetn = 1;
        @(posedge clock);
        #1;

        // Forwarding patterns
        ern = 5; ewreg = 1; mrn = 5; mwreg = 1; rs = 5;
        step();
        check_eq("fwd_ex_prio", 32'(fwda), 32'd1);
        ern = 0; mm2reg = 1; rt = 7;
        step();
        check_eq("fwd_mem_load", 32'(fwda), 32'd3);
        check_eq("fwd_nomatch", 32'(fwdb), 32'd0);
        idle();

        // Load-use: one bubble, then MEM load forwarded
        ern = 8; ewreg = 1; em2reg = 1; rt = 8; use_rt = 1; dtaken = 1;
        step();
        check_eq("lu_stall", 32'(o_wpcir), 32'd0);
        ewreg = 0; em2reg = 0; ern = 0; mrn = 8; mwreg = 1; mm2reg = 1;
        step();
        check_eq("lu_release", 32'(o_wpcir), 32'd1);
        check_eq("lu_fwdb", 32'(fwdb), 32'd3);
        idle();

        // Multiply/divide with dmd held through ISSUE
        md_sequence(starts, stalls);
        check_eq("md_starts", 32'(starts), 32'd1);
        check_eq("md_stalls", 32'(stalls), 32'(c_md));

        // lu and dmd together
        ern = 3; ewreg = 1; em2reg = 1; rs = 3; use_rs = 1; dmd = 1;
        step();
        check_eq("lu_dmd_nostart", 32'(o_start), 32'd0);
        ewreg = 0; em2reg = 0;
        step();
        check_eq("lu_dmd_start", 32'(o_start), 32'd1);
        idle();
        for (int i = 0; i < c_md; i++) step();

        // Reset asserted during the second WAIT cycle
        dmd = 1;
        step();
        dmd = 0;
        step();
        #2;
        resetn = 0;
        rs = 5; ern = 5; ewreg = 1; dtaken = 1;
        #1;
        check_reset_outputs("rst_wait");
        model_reset();
        idle();
        @(negedge clock);
        resetn = 1;
        @(posedge clock);
        #1;
        md_sequence(starts, stalls);
        check_eq("md2_starts", 32'(starts), 32'd1);
        check_eq("md2_stalls", 32'(stalls), 32'(c_md));

        // Randomized traffic with frequent register collisions
        for (int i = 0; i < 400; i++) begin
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            ern = 5'($urandom_range(0, 3));
            mrn = 5'($urandom_range(0, 3));
            use_rs = 1'($urandom); use_rt = 1'($urandom);
            ewreg = 1'($urandom); em2reg = 1'($urandom);
            mwreg = 1'($urandom); mm2reg = 1'($urandom);
            dmd = ($urandom_range(0, 5) == 0);
            dtaken = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline. It issues the operand-forwarding selects used in ID. It decides when the PC and IF/ID registers hold and when the ID/EX register loads a bubble. It sequences the multi-cycle multiply/divide unit by stalling ID for a fixed latency. It also flushes IF/ID on a taken branch resolved in ID.

## Interface
Parameters:
- MD_CYCLES, 4: multiply/divide latency in cycles; legal range 2..16.

Ports:
- clock  in  1  pipeline clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- rs, rt  in  5  source register fields of the instruction in ID.
- use_rs, use_rt  in  1  ID instruction reads rs / rt.
- dmd  in  1  ID instruction is a multiply/divide.
- dtaken  in  1  branch/jump in ID resolved taken.
- ern, mrn  in  5  destination register of the EX / MEM instruction.
- ewreg, em2reg  in  1  EX instruction writes the register file / is a load.
- mwreg, mm2reg  in  1  MEM instruction writes the register file / is a load.
- fwda, fwdb  out  2  operand select: 0 register file, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data.
- wpcir  out  1  PC and IF/ID write enable; 0 = hold.
- dbubble  out  1  ID/EX loads all-zero controls (wreg, m2reg, wmem, jal = 0).
- dflush  out  1  IF/ID loads a NOP.
- md_start  out  1  one-cycle start pulse to the multiply/divide unit.
- md_busy  out  1  controller is not in RUN.

## Operation
- Forwarding for fwda, using rs; fwdb is identical using rt. Priority order:
  - ewreg & ern≠0 & ern==rs & ~em2reg → 1.
  - Else mwreg & mrn≠0 & mrn==rs & ~mm2reg → 2.
  - Else mwreg & mrn≠0 & mrn==rs & mm2reg → 3.
  - Else 0.
  - Forwarding is computed in every state.
- Load-use condition: lu = ewreg & em2reg & ern≠0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- State machine, states RUN, WAIT, ISSUE; 4-bit down-counter cnt.
- RUN:
  - If lu: wpcir=0, dbubble=1; stay in RUN. A pending dmd does not start.
  - Else if dmd: md_start=1, wpcir=0, dbubble=1, cnt←MD_CYCLES−2, go to WAIT.
  - Else: wpcir=1, dbubble=0.
- WAIT:
  - Outputs: wpcir=0, dbubble=1, md_start=0.
  - If cnt==0 go to ISSUE; else cnt←cnt−1.
  - dmd and lu are ignored.
- ISSUE:
  - Outputs: wpcir=1, dbubble=0, md_start=0.
  - The held multiply/divide instruction advances to EX.
  - Always go to RUN. dmd in this cycle does not retrigger.
- dflush = dtaken & wpcir. A stall suppresses the flush; the branch is re-evaluated on the next cycle.
- md_busy = (state≠RUN).

## Timing
- Forwarding selects, lu, wpcir, dbubble and dflush are combinational from the inputs and the current state. State and cnt are registered on the rising edge of clock.
- Load-use stall lasts exactly 1 cycle when the EX load is followed by a bubble.
- Multiply/divide sequence:
  - Stall lasts MD_CYCLES cycles: the start cycle plus MD_CYCLES−1 WAIT cycles.
  - The ISSUE cycle follows the stall.
  - md_start rises exactly once per multiply/divide instruction.
- Reset:
  - Asynchronous assertion at any point, including mid-WAIT, forces state=RUN and cnt=0.
  - While resetn=0: fwda=fwdb=0, wpcir=1, dbubble=0, dflush=0, md_start=0, md_busy=0.
  - The first cycle after release is RUN.
- Simultaneous events:
  - lu and dmd in RUN → lu wins.
  - dtaken during lu or WAIT → no flush.
  - dtaken in ISSUE → flush.

## Configuration
- PIPE_HAZ_PERF_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on every cycle with wpcir=0.
  - flush_cnt increments on every cycle with dflush=1.
  - Both wrap modulo 2^32 and reset to 0 asynchronously.
- PIPE_HAZ_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Forwarding:
  - EX ALU writes r5, MEM ALU writes r5, rs=5 → fwda=1.
  - EX targets r0, MEM load writes r5, rs=5 → fwda=3.
  - rt=7 with no match → fwdb=0.
- Load-use: EX is a load to r8, ID uses rt=8 with use_rt=1 → exactly one cycle of wpcir=0 and dbubble=1. Next cycle, with MEM now holding the load (mrn=8, mm2reg=1), fwdb=3.
- MD_CYCLES=4, dmd=1 in RUN:
  - md_start=1 for one cycle.
  - wpcir=0 for 4 consecutive cycles, md_busy=1 for 4 cycles.
  - ISSUE cycle with wpcir=1, then RUN.
  - No second md_start while dmd stays 1 through ISSUE.
- lu and dmd together → 1-cycle load-use stall, then md_start on the following cycle.
- dtaken=1 in RUN with no stall → dflush=1. dtaken=1 during WAIT → dflush=0.
- Reset:
  - resetn pulsed low during the 2nd WAIT cycle → immediately md_busy=0 and wpcir=1.
  - After release, a new dmd restarts the full 4-cycle stall.
  - With PIPE_HAZ_PERF_EN defined, both counters read 0 after reset.
